// File: rtl/scanline_buffer.sv
// scanline_buffer: ping-pong line buffer, SDRAM burst fill of line DrawY+2, registered RGB888 out
// Clk/Reset_n: 50 MHz clock, async active-low reset
// pix_en/DrawX/DrawY: pixel strobe and position from the sync generator
// address/read_n/waitrequest/readdata/readdatavalid: Avalon-MM read master
// red/green/blue: registered pixel, 0 during blanking
// underrun/underrun_clr: sticky missed-deadline flag and its synchronous clear
module scanline_buffer #(
   parameter int          H_ACTIVE = 640,
   parameter int          H_TOTAL  = 800,
   parameter int          V_ACTIVE = 480,
   parameter int          V_TOTAL  = 525,
   parameter logic [24:0] FB_BASE  = 25'h0,
   parameter int          MAX_PEND = 8
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        pix_en,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic [24:0] address,
   output logic        read_n,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   input  logic        readdatavalid,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        underrun,
   input  logic        underrun_clr
);
   localparam logic [9:0]  X_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
   localparam logic [10:0] V_TOT  = 11'(V_TOTAL);
   localparam logic [9:0]  P_MAX  = 10'(MAX_PEND);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
   state_t      state, state_nx;
   logic        disp, back_valid, vis_q, pix_q;
   logic [9:0]  issue_cnt, recv_cnt, pend, tgt;
   logic [10:0] y2;
   logic [24:0] base;
   logic [23:0] rd_q;
   logic [23:0] bank [2][H_ACTIVE];
   logic        line_evt, start, rd_ok, fill_done, unused;
   assign unused    = ^readdata[31:24];
   assign line_evt  = pix_en && DrawX == X_LAST;
   assign y2        = {1'b0, DrawY} + 11'd2;
   assign tgt       = y2 >= V_TOT ? 10'(y2 - V_TOT) : y2[9:0];
   assign start     = line_evt && state == IDLE && tgt < V_ACT;
   assign pend      = issue_cnt - recv_cnt;
   assign read_n    = !(state == ISSUE && issue_cnt < H_ACT && pend < P_MAX);
   assign address   = base + 25'(issue_cnt);
   // responses arriving while idle are leftovers from an aborted fill
   assign rd_ok     = readdatavalid && state != IDLE && recv_cnt < H_ACT;
   assign fill_done = state == DRAIN && recv_cnt == H_ACT;
   always_comb begin
      state_nx = start ? ISSUE :
                 (state == ISSUE && issue_cnt == H_ACT) ? DRAIN :
                 fill_done ? IDLE : state;
   end
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         disp       <= 1'b0;
         back_valid <= 1'b0;
         issue_cnt  <= '0;
         recv_cnt   <= '0;
         base       <= '0;
         underrun   <= 1'b0;
         vis_q      <= 1'b0;
         pix_q      <= 1'b0;
         red        <= '0;
         green      <= '0;
         blue       <= '0;
      end else begin
         state <= state_nx;
         if (start) begin
            base      <= FB_BASE + 25'(tgt) * 25'(H_ACTIVE);
            issue_cnt <= '0;
            recv_cnt  <= '0;
         end else begin
            if (!read_n && !waitrequest) issue_cnt <= issue_cnt + 10'd1;
            if (rd_ok) recv_cnt <= recv_cnt + 10'd1;
         end
         underrun <= (line_evt && state != IDLE) ? 1'b1 : underrun_clr ? 1'b0 : underrun;
         if (line_evt && state == IDLE && back_valid) begin
            disp       <= ~disp;
            back_valid <= 1'b0;
         end else if (fill_done) begin
            back_valid <= 1'b1;
         end
         pix_q <= pix_en;
         if (pix_en) vis_q <= DrawX < H_ACT && DrawY < V_ACT;
         if (pix_q) {red, green, blue} <= vis_q ? rd_q : 24'h0;
      end
   end
   // bank contents are not reset
   always_ff @(posedge Clk) begin
      if (rd_ok) bank[~disp][recv_cnt] <= readdata[23:0];
      if (pix_en) rd_q <= bank[disp][DrawX];
   end
endmodule

// File: tb/tb_scanline_buffer.sv
// tb_scanline_buffer: directed checks of fill addressing, backpressure, pending limit, underrun, reset and display
module tb_scanline_buffer;
   logic        Clk = 1'b0, Reset_n = 1'b0, pix_en = 1'b0, waitrequest = 1'b0;
   logic        readdatavalid = 1'b0, underrun_clr = 1'b0;
   logic [9:0]  DrawX = '0, DrawY = '0;
   logic [31:0] readdata = '0;
   logic [24:0] address;
   logic        read_n, underrun;
   logic [7:0]  red, green, blue;
   int          n_chk = 0, n_pass = 0, n_acc = 0, addr_err = 0, cyc = 0;
   logic [24:0] exp_addr = '0;
   logic        hold = 1'b0, rel = 1'b0, flush = 1'b0;
   logic [24:0] q [$];
   scanline_buffer dut (
      .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en), .DrawX(DrawX), .DrawY(DrawY),
      .address(address), .read_n(read_n), .waitrequest(waitrequest), .readdata(readdata),
      .readdatavalid(readdatavalid), .red(red), .green(green), .blue(blue),
      .underrun(underrun), .underrun_clr(underrun_clr)
   );
   always #5 Clk = ~Clk;
   function automatic logic [31:0] mk(input logic [24:0] a);
      return {8'h00, a[7:0], ~a[7:0], 8'h5A};
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else n_pass++;
   endtask
   task automatic evt(input logic [9:0] y);
      DrawX = 10'd799;
      DrawY = y;
      pix_en = 1'b1;
      @(negedge Clk);
      pix_en = 1'b0;
      DrawX = '0;
   endtask
   task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y, input logic [23:0] exp);
      DrawX = x;
      DrawY = y;
      pix_en = 1'b1;
      @(negedge Clk);
      pix_en = 1'b0;
      @(negedge Clk);
      check(tag, {red, green, blue}, exp);
   endtask
   task automatic wait_bv();
      for (int i = 0; i < 2000 && !dut.back_valid; i++) begin
         @(negedge Clk);
         cyc++;
      end
   endtask
   // SDRAM model: in-order responses, at least one Clk after acceptance
   initial forever begin
      @(negedge Clk);
      #1;
      if (flush) begin
         q.delete();
         flush = 1'b0;
      end
      readdatavalid = 1'b0;
      if ((!hold || rel) && q.size() > 0) begin
         readdata = mk(q.pop_front());
         readdatavalid = 1'b1;
         rel = 1'b0;
      end
      if (Reset_n && !read_n && !waitrequest) begin
         if (address !== exp_addr) addr_err++;
         exp_addr++;
         n_acc++;
         q.push_back(address);
      end
   end
   initial begin
      repeat (3) @(negedge Clk);
      check("rst_read_n", read_n, 1);
      check("rst_addr", address, 0);
      check("rst_rgb", {red, green, blue}, 0);
      check("rst_underrun", underrun, 0);
      Reset_n = 1'b1;
      @(negedge Clk);
      exp_addr = 25'd3200;
      evt(10'd3);
      check("start_read_n", read_n, 0);
      check("start_addr", address, 3200);
      cyc = 1;
      for (int i = 0; i < 2000 && !(address == 25'd3300 && !read_n); i++) begin
         @(negedge Clk);
         cyc++;
      end
      waitrequest = 1'b1;
      repeat (10) @(negedge Clk);
      cyc += 10;
      check("stall_addr", address, 3300);
      check("stall_read_n", read_n, 0);
      check("stall_acc", n_acc, 100);
      waitrequest = 1'b0;
      wait_bv();
      check("fill_time", cyc < 1600, 1);
      check("fill_cnt", n_acc, 640);
      check("fill_order", addr_err, 0);
      check("fill_bv", dut.back_valid, 1);
      check("fill_idle_read_n", read_n, 1);
      hold = 1'b1;
      n_acc = 0;
      addr_err = 0;
      exp_addr = 25'd2560;
      evt(10'd2);
      check("swap_disp", dut.disp, 1);
      check("swap_bv", dut.back_valid, 0);
      repeat (20) @(negedge Clk);
      check("pend_acc", n_acc, 8);
      check("pend_read_n", read_n, 1);
      rel = 1'b1;
      repeat (6) @(negedge Clk);
      check("pend_one_acc", n_acc, 9);
      check("pend_one_read_n", read_n, 1);
      check("pend_order", addr_err, 0);
      evt(10'd3);
      check("ur_set", underrun, 1);
      check("ur_disp", dut.disp, 1);
      check("ur_nofill_addr", address, 2569);
      underrun_clr = 1'b1;
      @(negedge Clk);
      underrun_clr = 1'b0;
      check("ur_clr", underrun, 0);
      underrun_clr = 1'b1;
      evt(10'd3);
      underrun_clr = 1'b0;
      check("ur_set_wins", underrun, 1);
      Reset_n = 1'b0;
      #1;
      check("mid_rst_read_n", read_n, 1);
      check("mid_rst_addr", address, 0);
      check("mid_rst_underrun", underrun, 0);
      check("mid_rst_disp", dut.disp, 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      hold = 1'b0;
      repeat (15) @(negedge Clk);
      check("stray_bv", dut.back_valid, 0);
      check("stray_recv", dut.recv_cnt, 0);
      check("stray_read_n", read_n, 1);
      flush = 1'b1;
      @(negedge Clk);
      n_acc = 0;
      addr_err = 0;
      exp_addr = 25'd0;
      evt(10'd523);
      check("prime0_addr", address, 0);
      wait_bv();
      check("prime0_cnt", n_acc, 640);
      check("prime0_order", addr_err, 0);
      exp_addr = 25'd640;
      evt(10'd524);
      check("prime1_disp", dut.disp, 1);
      check("prime1_addr", address, 640);
      wait_bv();
      check("prime1_order", addr_err, 0);
      DrawX = 10'h25;
      DrawY = 10'd0;
      pix_en = 1'b1;
      @(negedge Clk);
      pix_en = 1'b0;
      check("pix_latency", {red, green, blue}, 0);
      @(negedge Clk);
      check("pix_25", {red, green, blue}, 24'h25DA5A);
      pix("pix_639", 10'd639, 10'd0, 24'h7F805A);
      @(negedge Clk);
      check("pix_hold", {red, green, blue}, 24'h7F805A);
      pix("pix_640_blank", 10'd640, 10'd0, 24'h0);
      pix("pix_10", 10'd10, 10'd0, 24'h0AF55A);
      pix("pix_y480_blank", 10'd10, 10'd480, 24'h0);
      evt(10'd478);
      check("nofill_read_n", read_n, 1);
      check("nofill_disp", dut.disp, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
